// File: rtl/dc_val_cache_if.sv
// ---------------------------------------------------------------------------
// dc_val_cache_if
// Bundles the core-side DC channel signals and the data memory handshake of
// dc_val_cache into one interface.
//   slave  modport : the cache itself (drives dc_vals, busy and mem_* requests)
//   master modport : the environment (core write/reload requests, memory
//                    ack and fetch data)
// Core side   : dc_vals, dc_write/_sel/_val, dc_reload/_sel/_addr, busy
// Memory side : mem_req, mem_we, mem_addr, mem_out, mem_ack, mem_in
// ---------------------------------------------------------------------------
interface dc_val_cache_if #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DC_COUNT   = 4
);
   localparam int SEL_WIDTH = $clog2(DC_COUNT);

   logic [DC_COUNT-1:0][WORD_WIDTH-1:0] dc_vals;
   logic                                dc_write;
   logic [SEL_WIDTH-1:0]                dc_write_sel;
   logic [WORD_WIDTH-1:0]               dc_write_val;
   logic                                dc_reload;
   logic [SEL_WIDTH-1:0]                dc_reload_sel;
   logic [ADDR_WIDTH-1:0]               dc_reload_addr;
   logic                                busy;
   logic                                mem_req;
   logic                                mem_we;
   logic [ADDR_WIDTH-1:0]               mem_addr;
   logic [WORD_WIDTH-1:0]               mem_out;
   logic                                mem_ack;
   logic [WORD_WIDTH-1:0]               mem_in;

   modport slave (
      output dc_vals, busy, mem_req, mem_we, mem_addr, mem_out,
      input  dc_write, dc_write_sel, dc_write_val,
      input  dc_reload, dc_reload_sel, dc_reload_addr,
      input  mem_ack, mem_in
   );

   modport master (
      input  dc_vals, busy, mem_req, mem_we, mem_addr, mem_out,
      output dc_write, dc_write_sel, dc_write_val,
      output dc_reload, dc_reload_sel, dc_reload_addr,
      output mem_ack, mem_in
   );
endinterface

// File: rtl/dc_val_cache.sv
// ---------------------------------------------------------------------------
// dc_val_cache
// Holds DC_COUNT data-cursor words, each with a backing memory address and
// valid/dirty flags. Core writes update a channel directly and mark it dirty.
// A reload replaces a channel's contents from memory through a single
// outstanding req/ack handshake, writing the old value back first when the
// channel is valid and dirty.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - dc_val_cache_if.slave (core channel access + memory handshake)
// ---------------------------------------------------------------------------
module dc_val_cache #(
   parameter int WORD_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DC_COUNT   = 4
) (
   input  logic           clk,
   input  logic           reset,
   dc_val_cache_if.slave  bus
);
   localparam int SEL_WIDTH = $clog2(DC_COUNT);

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

   state_t                              r_state;
   logic [DC_COUNT-1:0][WORD_WIDTH-1:0] r_vals;
   logic [ADDR_WIDTH-1:0]               r_addrs [DC_COUNT];
   logic [DC_COUNT-1:0]                 r_valid;
   logic [DC_COUNT-1:0]                 r_dirty;
   logic [SEL_WIDTH-1:0]                r_sel;
   logic [ADDR_WIDTH-1:0]               r_newAddr;
   logic                                r_busy;
   logic                                r_memReq;
   logic                                r_memWe;
   logic [ADDR_WIDTH-1:0]               r_memAddr;
   logic [WORD_WIDTH-1:0]               r_memOut;

   logic                                w_writeSelOk;
   logic                                w_reloadSelOk;
   logic                                w_reloadAccept;
   logic                                w_sameChan;
   logic                                w_writeAccept;
   logic                                w_victimDirty;
   logic [WORD_WIDTH-1:0]               w_victimData;

   // Request qualification. Selects beyond DC_COUNT only exist for
   // non-power-of-2 counts and are dropped. A write that lands together with
   // a reload of the same channel is folded into the victim (it is written
   // back if the channel is valid) instead of touching dc_vals, because the
   // fetch would overwrite it anyway. Writes to the channel currently being
   // reloaded are dropped so the fetched value cannot be clobbered.
   assign w_writeSelOk   = int'(bus.dc_write_sel) < DC_COUNT;
   assign w_reloadSelOk  = int'(bus.dc_reload_sel) < DC_COUNT;
   assign w_reloadAccept = bus.dc_reload && w_reloadSelOk && (r_state == IDLE);
   assign w_sameChan     = w_reloadAccept && bus.dc_write &&
                           (bus.dc_write_sel == bus.dc_reload_sel);
   assign w_writeAccept  = bus.dc_write && w_writeSelOk && !w_sameChan &&
                           !(r_busy && (bus.dc_write_sel == r_sel));
   assign w_victimDirty  = r_valid[bus.dc_reload_sel] &&
                           (r_dirty[bus.dc_reload_sel] || w_sameChan);
   assign w_victimData   = w_sameChan ? bus.dc_write_val : r_vals[bus.dc_reload_sel];

   // Channel storage and the reload FSM share one register block so that the
   // fetch completion can override any core write in the same cycle and all
   // memory-side outputs stay registered. mem_req is only ever high in
   // WRITEBACK/FETCH, so acks seen in IDLE are naturally ignored.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_vals    <= '0;
         for (int i = 0; i < DC_COUNT; i++) r_addrs[i] <= '0;
         r_valid   <= '0;
         r_dirty   <= '0;
         r_sel     <= '0;
         r_newAddr <= '0;
         r_busy    <= 1'b0;
         r_memReq  <= 1'b0;
         r_memWe   <= 1'b0;
         r_memAddr <= '0;
         r_memOut  <= '0;
      end else begin
         if (w_writeAccept) begin
            r_vals[bus.dc_write_sel]  <= bus.dc_write_val;
            r_dirty[bus.dc_write_sel] <= 1'b1;
         end

         unique case (r_state)
            IDLE: begin
               if (w_reloadAccept) begin
                  r_sel     <= bus.dc_reload_sel;
                  r_newAddr <= bus.dc_reload_addr;
                  r_busy    <= 1'b1;
                  r_memReq  <= 1'b1;
                  if (w_victimDirty) begin
                     r_state   <= WRITEBACK;
                     r_memWe   <= 1'b1;
                     r_memAddr <= r_addrs[bus.dc_reload_sel];
                     r_memOut  <= w_victimData;
                  end else begin
                     r_state   <= FETCH;
                     r_memWe   <= 1'b0;
                     r_memAddr <= bus.dc_reload_addr;
                  end
               end
            end

            // Writeback done: move straight to the fetch with req held high.
            WRITEBACK: begin
               if (bus.mem_ack) begin
                  r_state   <= FETCH;
                  r_memWe   <= 1'b0;
                  r_memAddr <= r_newAddr;
               end
            end

            FETCH: begin
               if (bus.mem_ack) begin
                  r_vals[r_sel]  <= bus.mem_in;
                  r_addrs[r_sel] <= r_newAddr;
                  r_valid[r_sel] <= 1'b1;
                  r_dirty[r_sel] <= 1'b0;
                  r_state        <= IDLE;
                  r_memReq       <= 1'b0;
                  r_busy         <= 1'b0;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.dc_vals  = r_vals;
   assign bus.busy     = r_busy;
   assign bus.mem_req  = r_memReq;
   assign bus.mem_we   = r_memWe;
   assign bus.mem_addr = r_memAddr;
   assign bus.mem_out  = r_memOut;
endmodule

// File: tb/tb_dc_val_cache.sv
// ---------------------------------------------------------------------------
// tb_dc_val_cache
// Directed bench for dc_val_cache. One 4-channel/32-bit instance covers the
// clean reload, dirty writeback, busy-time interactions, same-cycle
// write+reload and asynchronous reset; an 8-channel/16-bit instance covers
// back-to-back reloads at the channel extremes. Inputs change and outputs
// are sampled on the falling edge of the clock.
// ---------------------------------------------------------------------------
module tb_dc_val_cache;
   logic clk;
   logic reset;
   int   assertCount;
   int   failCount;

   dc_val_cache_if #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .DC_COUNT(4)) bus4 ();
   dc_val_cache_if #(.WORD_WIDTH(16), .ADDR_WIDTH(32), .DC_COUNT(8)) bus8 ();

   dc_val_cache #(.WORD_WIDTH(32), .ADDR_WIDTH(32), .DC_COUNT(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4.slave)
   );

   dc_val_cache #(.WORD_WIDTH(16), .ADDR_WIDTH(32), .DC_COUNT(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports observed/expected on a miss.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance one cycle: the DUT samples inputs on the rising edge and the
   // bench looks at the result on the following falling edge.
   task automatic applyStimulus();
      @(negedge clk);
   endtask

   // Directed sequence, each step annotated with the behaviour it exercises.
   initial begin
      assertCount = 0;
      failCount   = 0;
      reset = 1'b1;
      bus4.dc_write = 1'b0; bus4.dc_write_sel = '0; bus4.dc_write_val = '0;
      bus4.dc_reload = 1'b0; bus4.dc_reload_sel = '0; bus4.dc_reload_addr = '0;
      bus4.mem_ack = 1'b0; bus4.mem_in = '0;
      bus8.dc_write = 1'b0; bus8.dc_write_sel = '0; bus8.dc_write_val = '0;
      bus8.dc_reload = 1'b0; bus8.dc_reload_sel = '0; bus8.dc_reload_addr = '0;
      bus8.mem_ack = 1'b0; bus8.mem_in = '0;

      // Reset state
      applyStimulus();
      applyStimulus();
      checkOutput("rst_vals",   64'(bus4.dc_vals == '0), 64'd1);
      checkOutput("rst_busy",   64'(bus4.busy), 64'd0);
      checkOutput("rst_req",    64'(bus4.mem_req), 64'd0);
      checkOutput("rst_we",     64'(bus4.mem_we), 64'd0);
      checkOutput("rst_addr",   64'(bus4.mem_addr), 64'd0);
      checkOutput("rst_out",    64'(bus4.mem_out), 64'd0);
      reset = 1'b0;
      applyStimulus();

      // Clean reload of ch2 at 0x100, ack on the first request cycle
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd2; bus4.dc_reload_addr = 32'h100;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      checkOutput("t1_req",   64'(bus4.mem_req), 64'd1);
      checkOutput("t1_we",    64'(bus4.mem_we), 64'd0);
      checkOutput("t1_addr",  64'(bus4.mem_addr), 64'h100);
      checkOutput("t1_busy",  64'(bus4.busy), 64'd1);
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'hDEAD;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t1_val",   64'(bus4.dc_vals[2]), 64'hDEAD);
      checkOutput("t1_busy0", 64'(bus4.busy), 64'd0);
      checkOutput("t1_req0",  64'(bus4.mem_req), 64'd0);

      // Core write makes ch2 dirty; reload at 0x200 writes back then fetches
      bus4.dc_write = 1'b1; bus4.dc_write_sel = 2'd2; bus4.dc_write_val = 32'h1234;
      applyStimulus();
      bus4.dc_write = 1'b0;
      checkOutput("t2_wr", 64'(bus4.dc_vals[2]), 64'h1234);
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd2; bus4.dc_reload_addr = 32'h200;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      checkOutput("t2_wb_we",   64'(bus4.mem_we), 64'd1);
      checkOutput("t2_wb_addr", 64'(bus4.mem_addr), 64'h100);
      checkOutput("t2_wb_data", 64'(bus4.mem_out), 64'h1234);
      applyStimulus();
      applyStimulus();
      checkOutput("t2_wb_hold_req",  64'(bus4.mem_req), 64'd1);
      checkOutput("t2_wb_hold_addr", 64'(bus4.mem_addr), 64'h100);
      bus4.mem_ack = 1'b1;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t2_f_req",  64'(bus4.mem_req), 64'd1);
      checkOutput("t2_f_we",   64'(bus4.mem_we), 64'd0);
      checkOutput("t2_f_addr", 64'(bus4.mem_addr), 64'h200);
      applyStimulus();
      applyStimulus();
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'hBEEF;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t2_val",  64'(bus4.dc_vals[2]), 64'hBEEF);
      checkOutput("t2_busy", 64'(bus4.busy), 64'd0);
      // Dirty cleared: the next reload of ch2 goes straight to fetch
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd2; bus4.dc_reload_addr = 32'h300;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      checkOutput("t2_clean_we",   64'(bus4.mem_we), 64'd0);
      checkOutput("t2_clean_addr", 64'(bus4.mem_addr), 64'h300);
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'hCAFE;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t2_clean_val", 64'(bus4.dc_vals[2]), 64'hCAFE);

      // Busy reload of ch1: write ch0 lands, write ch1 and a second reload drop
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd1; bus4.dc_reload_addr = 32'h400;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      bus4.dc_write = 1'b1; bus4.dc_write_sel = 2'd0; bus4.dc_write_val = 32'h55;
      applyStimulus();
      bus4.dc_write_sel = 2'd1; bus4.dc_write_val = 32'h66;
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd3; bus4.dc_reload_addr = 32'h500;
      applyStimulus();
      bus4.dc_write = 1'b0; bus4.dc_reload = 1'b0;
      checkOutput("t3_ch0",  64'(bus4.dc_vals[0]), 64'h55);
      checkOutput("t3_ch1",  64'(bus4.dc_vals[1]), 64'h0);
      checkOutput("t3_addr", 64'(bus4.mem_addr), 64'h400);
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'h1111;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t3_val", 64'(bus4.dc_vals[1]), 64'h1111);
      applyStimulus();
      checkOutput("t3_no_second", 64'(bus4.mem_req), 64'd0);
      checkOutput("t3_busy",      64'(bus4.busy), 64'd0);

      // Make ch3 valid, then same-cycle write 0x77 + reload of ch3
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd3; bus4.dc_reload_addr = 32'h600;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'h3333;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      bus4.dc_write = 1'b1; bus4.dc_write_sel = 2'd3; bus4.dc_write_val = 32'h77;
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd3; bus4.dc_reload_addr = 32'h700;
      applyStimulus();
      bus4.dc_write = 1'b0; bus4.dc_reload = 1'b0;
      checkOutput("t4_wb_we",   64'(bus4.mem_we), 64'd1);
      checkOutput("t4_wb_addr", 64'(bus4.mem_addr), 64'h600);
      checkOutput("t4_wb_data", 64'(bus4.mem_out), 64'h77);
      checkOutput("t4_hidden",  64'(bus4.dc_vals[3]), 64'h3333);
      bus4.mem_ack = 1'b1;
      applyStimulus();
      checkOutput("t4_f_addr", 64'(bus4.mem_addr), 64'h700);
      checkOutput("t4_f_we",   64'(bus4.mem_we), 64'd0);
      bus4.mem_in = 32'h7777;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t4_val", 64'(bus4.dc_vals[3]), 64'h7777);

      // Reset asserted during a writeback of dirty ch2
      bus4.dc_write = 1'b1; bus4.dc_write_sel = 2'd2; bus4.dc_write_val = 32'hAAAA;
      applyStimulus();
      bus4.dc_write = 1'b0;
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd2; bus4.dc_reload_addr = 32'h800;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      checkOutput("t5_wb_we",   64'(bus4.mem_we), 64'd1);
      checkOutput("t5_wb_addr", 64'(bus4.mem_addr), 64'h300);
      #2 reset = 1'b1;
      #1;
      checkOutput("t5_rst_req",  64'(bus4.mem_req), 64'd0);
      checkOutput("t5_rst_busy", 64'(bus4.busy), 64'd0);
      checkOutput("t5_rst_vals", 64'(bus4.dc_vals == '0), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      bus4.dc_reload = 1'b1; bus4.dc_reload_sel = 2'd2; bus4.dc_reload_addr = 32'h900;
      applyStimulus();
      bus4.dc_reload = 1'b0;
      checkOutput("t5_fetch_we",   64'(bus4.mem_we), 64'd0);
      checkOutput("t5_fetch_addr", 64'(bus4.mem_addr), 64'h900);
      bus4.mem_ack = 1'b1; bus4.mem_in = 32'h9999;
      applyStimulus();
      bus4.mem_ack = 1'b0;
      checkOutput("t5_val", 64'(bus4.dc_vals[2]), 64'h9999);

      // 8-channel, 16-bit instance: back-to-back reloads of ch7 then ch0
      bus8.dc_reload = 1'b1; bus8.dc_reload_sel = 3'd7; bus8.dc_reload_addr = 32'h70;
      applyStimulus();
      bus8.dc_reload = 1'b0;
      checkOutput("t6_addr7", 64'(bus8.mem_addr), 64'h70);
      checkOutput("t6_we7",   64'(bus8.mem_we), 64'd0);
      bus8.mem_ack = 1'b1; bus8.mem_in = 16'hA7A7;
      applyStimulus();
      bus8.mem_ack = 1'b0;
      bus8.dc_reload = 1'b1; bus8.dc_reload_sel = 3'd0; bus8.dc_reload_addr = 32'h10;
      applyStimulus();
      bus8.dc_reload = 1'b0;
      checkOutput("t6_val7",  64'(bus8.dc_vals[7]), 64'hA7A7);
      checkOutput("t6_addr0", 64'(bus8.mem_addr), 64'h10);
      checkOutput("t6_req0",  64'(bus8.mem_req), 64'd1);
      bus8.mem_ack = 1'b1; bus8.mem_in = 16'h0B0B;
      applyStimulus();
      bus8.mem_ack = 1'b0;
      checkOutput("t6_val0",   64'(bus8.dc_vals[0]), 64'h0B0B);
      checkOutput("t6_val7b",  64'(bus8.dc_vals[7]), 64'hA7A7);
      checkOutput("t6_busy",   64'(bus8.busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
